// File: rtl/fpu_mul_sched_if.sv
// Request, multiplier and response bundle for the shared mantissa-multiplier scheduler.
// slave = the scheduler, master = the FPU sequencers plus the multiplier instance.
interface fpu_mul_sched_if #(
    parameter int NREQ    = 3,
    parameter int A_WIDTH = 24,
    parameter int B_WIDTH = 24
);
    logic [NREQ-1:0]              req_valid;
    logic [NREQ*A_WIDTH-1:0]      req_a;
    logic [NREQ*B_WIDTH-1:0]      req_b;
    logic [NREQ-1:0]              req_ready;
    logic                         flush;
    logic [A_WIDTH-1:0]           mul_a;
    logic [B_WIDTH-1:0]           mul_b;
    logic [A_WIDTH+B_WIDTH-1:0]   mul_product;
    logic [NREQ-1:0]              rsp_valid;
    logic [A_WIDTH+B_WIDTH-1:0]   rsp_product;
    logic                         busy;

    modport slave (
        input  req_valid, req_a, req_b, flush, mul_product,
        output req_ready, mul_a, mul_b, rsp_valid, rsp_product, busy
    );

    modport master (
        output req_valid, req_a, req_b, flush, mul_product,
        input  req_ready, mul_a, mul_b, rsp_valid, rsp_product, busy
    );
endinterface

// File: rtl/fpu_mul_sched.sv
// Single-issue scheduler for the pipelined mantissa multiplier with tag tracking of owners.
// Define FPU_MUL_SCHED_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module fpu_mul_sched #(
    parameter int NREQ    = 3,
    parameter int A_WIDTH = 24,
    parameter int B_WIDTH = 24,
    parameter int LATENCY = 3
) (
    input logic             clk,
    input logic             rst_n,
    fpu_mul_sched_if.slave  bus
);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]    grant;
    logic               accept;
    logic [A_WIDTH-1:0] sel_a;
    logic [B_WIDTH-1:0] sel_b;
    logic [A_WIDTH-1:0] mul_a_q;
    logic [B_WIDTH-1:0] mul_b_q;
    logic [LATENCY:0]   stage_valid;
    logic [NREQ-1:0]    stage_owner [LATENCY+1];

`ifdef FPU_MUL_SCHED_FIXED_PRIO_EN
    always_comb begin
        logic found;
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && bus.req_valid[PTR_W'(i)]) begin
                found = 1'b1;
                grant[PTR_W'(i)] = 1'b1;
            end
        end
    end
`else
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] grant_idx;

    // Search begins one past the last winner and wraps modulo NREQ.
    always_comb begin
        logic             found;
        logic [PTR_W-1:0] idx;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = PTR_W'((int'(rr_ptr) + k) % NREQ);
            if (!found && bus.req_valid[idx]) begin
                found     = 1'b1;
                grant[idx] = 1'b1;
                grant_idx = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= PTR_W'(NREQ - 1);
        end else if (accept) begin
            rr_ptr <= grant_idx;
        end
    end
`endif

    assign bus.req_ready = (rst_n && !bus.flush) ? grant : '0;
    assign accept        = |bus.req_ready;

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[PTR_W'(i)]) begin
                sel_a = bus.req_a[i*A_WIDTH +: A_WIDTH];
                sel_b = bus.req_b[i*B_WIDTH +: B_WIDTH];
            end
        end
    end

    // Operands only load on an accepted request so the multiplier inputs stay quiet when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a_q <= '0;
            mul_b_q <= '0;
        end else if (accept) begin
            mul_a_q <= sel_a;
            mul_b_q <= sel_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid <= '0;
            for (int i = 0; i <= LATENCY; i++) stage_owner[i] <= '0;
        end else if (bus.flush) begin
            stage_valid <= '0;
            for (int i = 0; i <= LATENCY; i++) stage_owner[i] <= '0;
        end else begin
            stage_valid    <= {stage_valid[LATENCY-1:0], accept};
            stage_owner[0] <= bus.req_ready;
            for (int i = 1; i <= LATENCY; i++) stage_owner[i] <= stage_owner[i-1];
        end
    end

    assign bus.mul_a       = mul_a_q;
    assign bus.mul_b       = mul_b_q;
    assign bus.rsp_valid   = stage_valid[LATENCY] ? stage_owner[LATENCY] : '0;
    assign bus.rsp_product = bus.mul_product;
    assign bus.busy        = |stage_valid;
endmodule

// File: tb/tb_fpu_mul_sched.sv
// Directed bench for fpu_mul_sched: reset, single op, round-robin stream, fixed-priority
// starvation pattern, flush and asynchronous mid-operation reset.
module tb_fpu_mul_sched;
    localparam int NREQ    = 3;
    localparam int A_WIDTH = 24;
    localparam int B_WIDTH = 24;
    localparam int LATENCY = 3;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    fpu_mul_sched_if #(.NREQ(NREQ), .A_WIDTH(A_WIDTH), .B_WIDTH(B_WIDTH)) bus ();

    fpu_mul_sched #(
        .NREQ(NREQ), .A_WIDTH(A_WIDTH), .B_WIDTH(B_WIDTH), .LATENCY(LATENCY)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [23:0] a_vals [3];
    logic [23:0] b_vals [3];

    task automatic apply_stimulus(input logic [2:0] valid, input logic flush,
                                  input logic [47:0] product);
        @(posedge clk);
        #1;
        bus.req_valid   = valid;
        bus.flush       = flush;
        bus.mul_product = product;
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic int owner_index(input logic [2:0] onehot);
        int r;
        r = 0;
        if (onehot[1]) r = 1;
        if (onehot[2]) r = 2;
        return r;
    endfunction

    initial begin
        logic [2:0]  exp_grant [6];
        logic [2:0]  exp_starve [3];
        logic [2:0]  exp_rsp;
        logic [2:0]  valid;
        logic [47:0] prod;

        checks = 0;
        errors = 0;
        a_vals[0] = 24'h800000; b_vals[0] = 24'h800000;
        a_vals[1] = 24'h000004; b_vals[1] = 24'h000005;
        a_vals[2] = 24'h000006; b_vals[2] = 24'h000007;
`ifdef FPU_MUL_SCHED_FIXED_PRIO_EN
        exp_grant  = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
        exp_starve = '{3'b010, 3'b010, 3'b010};
`else
        exp_grant  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        exp_starve = '{3'b010, 3'b100, 3'b010};
`endif
        bus.req_a       = {a_vals[2], a_vals[1], a_vals[0]};
        bus.req_b       = {b_vals[2], b_vals[1], b_vals[0]};
        bus.req_valid   = 3'b001;
        bus.flush       = 1'b0;
        bus.mul_product = '0;
        rst_n           = 1'b0;

        $display("[TB] reset state");
        #12;
        check_output("reset_ready", bus.req_ready, 3'b000);
        check_output("reset_mul_a", bus.mul_a, 24'h0);
        check_output("reset_mul_b", bus.mul_b, 24'h0);
        check_output("reset_rsp", bus.rsp_valid, 3'b000);
        check_output("reset_busy", bus.busy, 1'b0);
        bus.req_valid = 3'b000;
        #10;
        rst_n = 1'b1;

        $display("[TB] single multiply");
        apply_stimulus(3'b001, 1'b0, 48'h0);
        check_output("t1_ready", bus.req_ready, 3'b001);
        apply_stimulus(3'b000, 1'b0, 48'h0);
        check_output("t1_mul_a", bus.mul_a, 24'h800000);
        check_output("t1_mul_b", bus.mul_b, 24'h800000);
        check_output("t1_busy", bus.busy, 1'b1);
        check_output("t1_rsp_early1", bus.rsp_valid, 3'b000);
        apply_stimulus(3'b000, 1'b0, 48'h0);
        check_output("t1_rsp_early2", bus.rsp_valid, 3'b000);
        apply_stimulus(3'b000, 1'b0, 48'h0);
        check_output("t1_rsp_early3", bus.rsp_valid, 3'b000);
        apply_stimulus(3'b000, 1'b0, 48'h400000_000000);
        check_output("t1_rsp_valid", bus.rsp_valid, 3'b001);
        check_output("t1_rsp_product", bus.rsp_product, 48'h400000_000000);
        check_output("t1_busy_last", bus.busy, 1'b1);
        apply_stimulus(3'b000, 1'b0, 48'h0);
        check_output("t1_rsp_after", bus.rsp_valid, 3'b000);
        check_output("t1_busy_idle", bus.busy, 1'b0);
        check_output("t1_hold_a", bus.mul_a, 24'h800000);

        @(posedge clk);
        #2 rst_n = 1'b0;
        #4 rst_n = 1'b1;

        $display("[TB] continuous requests from all requesters");
        for (int k = 0; k <= 10; k++) begin
            valid = (k < 6) ? 3'b111 : 3'b000;
            prod  = 48'(k) * 48'h010101;
            apply_stimulus(valid, 1'b0, prod);
            check_output("t2_ready", bus.req_ready, (k < 6) ? exp_grant[k] : 3'b000);
            exp_rsp = (k >= 4 && k <= 9) ? exp_grant[k-4] : 3'b000;
            check_output("t2_rsp", bus.rsp_valid, exp_rsp);
            if (exp_rsp != 3'b000) check_output("t2_rsp_product", bus.rsp_product, prod);
            check_output("t2_busy", bus.busy, (k >= 1 && k <= 9) ? 1'b1 : 1'b0);
            if (k == 0)
                check_output("t2_mul_a", bus.mul_a, 24'h0);
            else
                check_output("t2_mul_a", bus.mul_a,
                             a_vals[owner_index(exp_grant[(k - 1 > 5) ? 5 : k - 1])]);
        end

        $display("[TB] requesters 1 and 2 held");
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(3'b110, 1'b0, 48'h0);
            check_output("t3_ready", bus.req_ready, exp_starve[k]);
        end
        repeat (5) apply_stimulus(3'b000, 1'b0, 48'h0);
        check_output("t3_drained", bus.busy, 1'b0);

        $display("[TB] flush with operations in flight");
        apply_stimulus(3'b001, 1'b0, 48'h0);
        check_output("t4_ready0", bus.req_ready, 3'b001);
        apply_stimulus(3'b010, 1'b0, 48'h0);
        check_output("t4_ready1", bus.req_ready, 3'b010);
        apply_stimulus(3'b001, 1'b0, 48'h0);
        check_output("t4_ready2", bus.req_ready, 3'b001);
        apply_stimulus(3'b100, 1'b0, 48'h0);
        check_output("t4_ready3", bus.req_ready, 3'b100);
        apply_stimulus(3'b010, 1'b1, 48'hABCDEF_012345);
        check_output("t4_flush_ready", bus.req_ready, 3'b000);
        check_output("t4_flush_rsp", bus.rsp_valid, 3'b001);
        check_output("t4_flush_product", bus.rsp_product, 48'hABCDEF_012345);
        check_output("t4_flush_busy", bus.busy, 1'b1);
        apply_stimulus(3'b000, 1'b0, 48'h0);
        check_output("t4_post_rsp", bus.rsp_valid, 3'b000);
        check_output("t4_post_busy", bus.busy, 1'b0);
        check_output("t4_hold_a", bus.mul_a, 24'h000006);
        check_output("t4_hold_b", bus.mul_b, 24'h000007);
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(3'b000, 1'b0, 48'h0);
            check_output("t4_quiet_rsp", bus.rsp_valid, 3'b000);
        end

        $display("[TB] asynchronous reset mid-operation");
        apply_stimulus(3'b010, 1'b0, 48'h0);
        check_output("t5_ready0", bus.req_ready, 3'b010);
        apply_stimulus(3'b100, 1'b0, 48'h0);
        check_output("t5_ready1", bus.req_ready, 3'b100);
        apply_stimulus(3'b000, 1'b0, 48'h0);
        check_output("t5_busy_before", bus.busy, 1'b1);
        check_output("t5_mul_a_before", bus.mul_a, 24'h000006);
        #1 rst_n = 1'b0;
        #1;
        check_output("t5_rst_rsp", bus.rsp_valid, 3'b000);
        check_output("t5_rst_busy", bus.busy, 1'b0);
        check_output("t5_rst_mul_a", bus.mul_a, 24'h0);
        check_output("t5_rst_mul_b", bus.mul_b, 24'h0);
        bus.req_valid = 3'b111;
        #1;
        check_output("t5_rst_ready", bus.req_ready, 3'b000);
        bus.req_valid = 3'b000;
        #1 rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            apply_stimulus(3'b000, 1'b0, 48'h0);
            check_output("t5_no_rsp", bus.rsp_valid, 3'b000);
            check_output("t5_no_busy", bus.busy, 1'b0);
        end
        apply_stimulus(3'b111, 1'b0, 48'h0);
        check_output("t5_first_grant", bus.req_ready, 3'b001);
        apply_stimulus(3'b000, 1'b0, 48'h0);
        check_output("t5_new_mul_a", bus.mul_a, 24'h800000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
